// File: rtl/regfile_writeback.sv
// Writeback stage: sole driver of the register-file rd write port.
// Merges in-order memory-stage results and buffered mul/div results.
// Ports: clk, rst_n; mem_* (memory-stage result + load extraction,
//   mem_ready backpressure); md_* (mul/div result handshake and issue
//   tracking); pending_mask (outstanding mul/div destinations);
//   rd_enable/rd_sel/rd_data (registered write port).
// Optional macro WB_RETIRE_COUNT_EN adds a 64-bit retire_count output.
module regfile_writeback #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        mem_is_load,
  input  logic [1:0]  mem_load_size,
  input  logic        mem_load_signed,
  input  logic [1:0]  mem_load_addr_lo,
  input  logic [31:0] mem_load_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  input  logic        md_issue_valid,
  input  logic [4:0]  md_issue_rd,
  output logic [31:0] pending_mask,
  output logic        rd_enable,
  output logic [4:0]  rd_sel,
  output logic [31:0] rd_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0] retire_count
`endif
);

  localparam logic [3:0] LP_LIM = 4'(STARVE_LIMIT);

  logic        r_buf_v;
  logic [4:0]  r_buf_rd;
  logic [31:0] r_buf_data;
  logic [3:0]  r_starve;
  logic [31:0] r_pend;
  logic        r_rd_en;
  logic [4:0]  r_rd_sel;
  logic [31:0] r_rd_data;

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_mem_data;
  logic        w_force;
  logic        w_mem_wr;
  logic        w_drain;
  logic        w_md_acc;
  logic        w_wr_en;
  logic [4:0]  w_wr_sel;
  logic [31:0] w_wr_data;
  logic [3:0]  w_starve_nx;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_pend_nx;

  assign w_shift = mem_load_data >> {mem_load_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = mem_load_addr_lo[1] ? mem_load_data[31:16]
                                       : mem_load_data[15:0];

  always_comb begin
    w_load = mem_load_data;
    unique case (mem_load_size)
      2'b00: w_load = {{24{mem_load_signed & w_byte[7]}}, w_byte};
      2'b01: w_load = {{16{mem_load_signed & w_half[15]}}, w_half};
      default: w_load = mem_load_data;
    endcase
  end

  assign w_mem_data = mem_is_load ? w_load : mem_result;

  // A full buffer that has waited STARVE_LIMIT cycles preempts memory.
  assign w_force  = r_buf_v && (r_starve == LP_LIM);
  assign w_mem_wr = !w_force && mem_valid && (mem_rd != 5'd0);
  assign w_drain  = r_buf_v && !w_mem_wr;
  // Accept only into an empty buffer; rd=0 results are dropped.
  assign w_md_acc = md_valid && !r_buf_v && (md_rd != 5'd0);

  assign mem_ready = !w_force;
  assign md_ready  = !r_buf_v;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sel  = 5'd0;
    w_wr_data = 32'd0;
    unique case (1'b1)
      w_mem_wr: begin
        w_wr_en   = 1'b1;
        w_wr_sel  = mem_rd;
        w_wr_data = w_mem_data;
      end
      w_drain: begin
        w_wr_en   = 1'b1;
        w_wr_sel  = r_buf_rd;
        w_wr_data = r_buf_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_starve_nx = r_starve;
    if (!r_buf_v || w_drain)
      w_starve_nx = 4'd0;
    else if (r_starve != LP_LIM)
      w_starve_nx = r_starve + 4'd1;
  end

  assign w_set = (md_issue_valid && md_issue_rd != 5'd0)
               ? (32'd1 << md_issue_rd) : 32'd0;
  assign w_clr = w_drain ? (32'd1 << r_buf_rd) : 32'd0;
  // Set applied after clear so a same-cycle reissue keeps the bit.
  assign w_pend_nx = ((r_pend & ~w_clr) | w_set) & ~32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_v    <= 1'b0;
      r_buf_rd   <= 5'd0;
      r_buf_data <= 32'd0;
      r_starve   <= 4'd0;
      r_pend     <= 32'd0;
      r_rd_en    <= 1'b0;
      r_rd_sel   <= 5'd0;
      r_rd_data  <= 32'd0;
    end else begin
      r_rd_en   <= w_wr_en;
      r_rd_sel  <= w_wr_sel;
      r_rd_data <= w_wr_data;
      r_starve  <= w_starve_nx;
      r_pend    <= w_pend_nx;
      if (w_drain) begin
        r_buf_v <= 1'b0;
      end else if (w_md_acc) begin
        r_buf_v    <= 1'b1;
        r_buf_rd   <= md_rd;
        r_buf_data <= md_result;
      end
    end
  end

  assign pending_mask = r_pend;
  assign rd_enable    = r_rd_en;
  assign rd_sel       = r_rd_sel;
  assign rd_data      = r_rd_data;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] r_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_retire <= 64'd0;
    else if (r_rd_en)
      r_retire <= r_retire + 64'd1;
  end

  assign retire_count = r_retire;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed literal checks plus
// randomized traffic compared each cycle against a behavioural model.
module tb_regfile_writeback;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [1:0]  mem_load_size;
  logic        mem_load_signed;
  logic [1:0]  mem_load_addr_lo;
  logic [31:0] mem_load_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_issue_valid;
  logic [4:0]  md_issue_rd;
  logic [31:0] pending_mask;
  logic        rd_enable;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_writeback #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .mem_is_load(mem_is_load), .mem_load_size(mem_load_size),
    .mem_load_signed(mem_load_signed),
    .mem_load_addr_lo(mem_load_addr_lo),
    .mem_load_data(mem_load_data),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_rd(md_rd), .md_result(md_result),
    .md_issue_valid(md_issue_valid), .md_issue_rd(md_issue_rd),
    .pending_mask(pending_mask),
    .rd_enable(rd_enable), .rd_sel(rd_sel), .rd_data(rd_data)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Value a load must return, from the lane-selection rules.
  function automatic logic [31:0] load_val(input logic [1:0] sz,
      input logic sg, input logic [1:0] a, input logic [31:0] d);
    int lane;
    logic [31:0] v;
    if (sz == 2'b00) begin
      lane = int'(a);
      v = (d / (32'd1 << (8 * lane))) % 32'd256;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'b01) begin
      lane = a[1] ? 1 : 0;
      v = (d / (32'd1 << (16 * lane))) % 32'd65536;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Behavioural model state.
  bit          m_bv;
  bit   [4:0]  m_brd;
  bit   [31:0] m_bdata;
  int          m_wait;
  bit          m_pend [32];
  bit          e_en;
  bit   [4:0]  e_sel;
  bit   [31:0] e_data;
  longint unsigned e_cnt;

  always @(negedge clk) begin
    bit f;
    bit n_en;
    bit [4:0] n_sel;
    bit [31:0] n_data;
    bit [31:0] pm;
    int clr;
    if (!rst_n) begin
      m_bv = 0; m_wait = 0; e_en = 0; e_sel = 0; e_data = 0;
      e_cnt = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end
    pm = 0;
    foreach (m_pend[i]) if (m_pend[i]) pm = pm | (32'd1 << i);
    f = m_bv && (m_wait == LIM);
    chk("m_rd_enable", {63'd0, rd_enable}, {63'd0, e_en});
    if (e_en || !rst_n) begin
      chk("m_rd_sel", {59'd0, rd_sel}, {59'd0, e_sel});
      chk("m_rd_data", {32'd0, rd_data}, {32'd0, e_data});
    end
    chk("m_pending", {32'd0, pending_mask}, {32'd0, pm});
    chk("m_md_ready", {63'd0, md_ready}, {63'd0, !m_bv});
    chk("m_mem_ready", {63'd0, mem_ready}, {63'd0, !f});
`ifdef WB_RETIRE_COUNT_EN
    chk("m_retire", retire_count, e_cnt);
`endif
    if (rst_n) begin
      if (e_en) e_cnt = e_cnt + 1;
      n_en = 0; n_sel = 0; n_data = 0; clr = -1;
      if (f || (m_bv && !(mem_valid && mem_rd != 0))) begin
        n_en = 1; n_sel = m_brd; n_data = m_bdata; clr = m_brd;
      end else if (mem_valid && mem_rd != 0) begin
        n_en = 1; n_sel = mem_rd;
        n_data = mem_is_load ? load_val(mem_load_size,
                   mem_load_signed, mem_load_addr_lo, mem_load_data)
                 : mem_result;
        if (m_bv && m_wait < LIM) m_wait++;
      end
      if (clr >= 0) begin
        m_bv = 0;
        m_pend[clr] = 0;
      end else if (!m_bv && md_valid && md_rd != 0) begin
        m_bv = 1; m_brd = md_rd; m_bdata = md_result;
      end
      if (clr >= 0 || !m_bv) m_wait = 0;
      if (md_issue_valid && md_issue_rd != 0) m_pend[md_issue_rd] = 1;
      e_en = n_en; e_sel = n_sel; e_data = n_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit accm, accd;
    rst_n = 0;
    mem_valid = 0; mem_rd = 0; mem_result = 0; mem_is_load = 0;
    mem_load_size = 0; mem_load_signed = 0; mem_load_addr_lo = 0;
    mem_load_data = 0; md_valid = 0; md_rd = 0; md_result = 0;
    md_issue_valid = 0; md_issue_rd = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_rd_enable", {63'd0, rd_enable}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_pending", {32'd0, pending_mask}, 64'd0);
    step();
    rst_n = 1;

    // rd=0 issue and result are ignored.
    md_issue_valid = 1; md_issue_rd = 0;
    md_valid = 1; md_rd = 0; md_result = 32'h55;
    @(negedge clk);
    chk("rd0_md_ready", {63'd0, md_ready}, 64'd1);
    step();
    md_issue_valid = 0; md_valid = 0;
    @(negedge clk);
    chk("rd0_pending", {32'd0, pending_mask}, 64'd0);
    chk("rd0_md_ready2", {63'd0, md_ready}, 64'd1);
    step();
    @(negedge clk);
    chk("rd0_no_write", {63'd0, rd_enable}, 64'd0);
    step();

    // Loads: lb and lhu.
    mem_valid = 1; mem_rd = 5; mem_is_load = 1; mem_load_size = 0;
    mem_load_signed = 1; mem_load_addr_lo = 3;
    mem_load_data = 32'h80AB_CDEF;
    @(negedge clk);
    step();
    mem_rd = 6; mem_load_size = 1; mem_load_signed = 0;
    mem_load_addr_lo = 2;
    @(negedge clk);
    chk("lb_en", {63'd0, rd_enable}, 64'd1);
    chk("lb_sel", {59'd0, rd_sel}, 64'd5);
    chk("lb_data", {32'd0, rd_data}, 64'hFFFF_FF80);
    step();
    mem_valid = 0; mem_is_load = 0;
    @(negedge clk);
    chk("lhu_data", {32'd0, rd_data}, 64'h0000_80AB);
    step();

    // Mul/div latency.
    md_valid = 1; md_rd = 7; md_result = 32'h1234;
    @(negedge clk);
    chk("md_ready_idle", {63'd0, md_ready}, 64'd1);
    step();
    md_valid = 0;
    @(negedge clk);
    chk("md_ready_busy", {63'd0, md_ready}, 64'd0);
    chk("md_no_early", {63'd0, rd_enable}, 64'd0);
    step();
    @(negedge clk);
    chk("md_sel", {59'd0, rd_sel}, 64'd7);
    chk("md_data", {32'd0, rd_data}, 64'h1234);
    chk("md_ready_back", {63'd0, md_ready}, 64'd1);
    step();

    // Starvation.
    mem_valid = 1; mem_rd = 3; mem_result = 100;
    md_valid = 1; md_rd = 8; md_result = 32'hBEEF;
    @(negedge clk);
    step();
    md_valid = 0; mem_result = 101;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("starve_mem_ready", {63'd0, mem_ready}, 64'd1);
      step();
      mem_result = mem_result + 1;
    end
    @(negedge clk);
    chk("starve_force", {63'd0, mem_ready}, 64'd0);
    chk("starve_last_mem", {32'd0, rd_data}, 64'd104);
    step();
    @(negedge clk);
    chk("starve_buf_sel", {59'd0, rd_sel}, 64'd8);
    chk("starve_buf_data", {32'd0, rd_data}, 64'hBEEF);
    step();
    mem_valid = 0;
    @(negedge clk);
    chk("starve_held", {32'd0, rd_data}, 64'd105);
    step();

    // Scoreboard, including set-wins.
    md_issue_valid = 1; md_issue_rd = 9;
    @(negedge clk);
    step();
    md_issue_valid = 0;
    @(negedge clk);
    chk("sb_set", {32'd0, pending_mask}, 64'h200);
    step();
    md_valid = 1; md_rd = 9; md_result = 32'h99;
    @(negedge clk);
    step();
    md_valid = 0; md_issue_valid = 1; md_issue_rd = 9;
    @(negedge clk);
    step();
    md_issue_valid = 0;
    @(negedge clk);
    chk("sb_drain_sel", {59'd0, rd_sel}, 64'd9);
    chk("sb_set_wins", {32'd0, pending_mask}, 64'h200);
    step();

    // Reset mid-operation.
    md_valid = 1; md_rd = 10; md_result = 32'hAA;
    mem_valid = 1; mem_rd = 3; mem_result = 32'h33;
    @(negedge clk);
    step();
    md_valid = 0;
    @(negedge clk);
    chk("prerst_full", {63'd0, md_ready}, 64'd0);
    chk("prerst_pend", {32'd0, pending_mask}, 64'h200);
    #2 rst_n = 0;
    #1;
    chk("rst_async_en", {63'd0, rd_enable}, 64'd0);
    chk("rst_async_sel", {59'd0, rd_sel}, 64'd0);
    chk("rst_async_data", {32'd0, rd_data}, 64'd0);
    chk("rst_async_pend", {32'd0, pending_mask}, 64'd0);
    step();
    mem_valid = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rst_md_ready", {63'd0, md_ready}, 64'd1);
`ifdef WB_RETIRE_COUNT_EN
    chk("rst_retire", retire_count, 64'd0);
`endif
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      accm = mem_valid && mem_ready;
      accd = md_valid && md_ready;
      step();
      if (!mem_valid || accm) begin
        mem_valid = ($urandom % 4) != 0;
        mem_rd = 5'($urandom_range(0, 31));
        mem_result = $urandom;
        mem_is_load = $urandom % 2;
        mem_load_size = 2'($urandom);
        mem_load_signed = $urandom % 2;
        mem_load_addr_lo = 2'($urandom);
        mem_load_data = $urandom;
      end
      if (!md_valid || accd) begin
        md_valid = ($urandom % 3) == 0;
        md_rd = 5'($urandom_range(0, 31));
        md_result = $urandom;
      end
      md_issue_valid = ($urandom % 4) == 0;
      md_issue_rd = 5'($urandom_range(0, 31));
    end
    mem_valid = 0; md_valid = 0; md_issue_valid = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage: the sole write-side driver of the register file's single rd write port (rd_enable/rd_sel/rd_data).
- Merges two result sources into one registered write per cycle:
  - in-order memory-stage results, including load extraction and extension;
  - out-of-order results from the multi-cycle mul/div unit, held in a one-entry buffer.
- Keeps a pending-destination scoreboard that decode uses to stall on outstanding mul/div writes.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a full mul/div buffer may wait before the memory stage is stalled to drain it (1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  memory-stage result valid
- mem_ready  out  1  memory-stage result accepted this cycle
- mem_rd  in  5  destination register
- mem_result  in  32  ALU/CSR result (non-load)
- mem_is_load  in  1  result comes from mem_load_data
- mem_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_load_signed  in  1  sign-extend byte/half
- mem_load_addr_lo  in  2  address bits [1:0]
- mem_load_data  in  32  raw aligned bus word
- md_valid  in  1  mul/div result valid
- md_ready  out  1  mul/div result accepted
- md_rd  in  5  mul/div destination
- md_result  in  32  mul/div result
- md_issue_valid  in  1  decode issued a mul/div op
- md_issue_rd  in  5  its destination
- pending_mask  out  32  bit n set = mul/div write to xn outstanding
- rd_enable  out  1  register-file write enable
- rd_sel  out  5  register-file write index
- rd_data  out  32  register-file write data

Behaviour:
- Reset (async, rst_n low): rd_enable=0, rd_sel=0, rd_data=0, buffer empty, starve counter=0, pending_mask=0. After reset: mem_ready=1, md_ready=1.
- rd_* are registered. A write selected in cycle N appears on rd_* in cycle N+1, for exactly one cycle. rd_enable is never asserted with rd_sel=0.
- Load extraction:
  - Byte: lane mem_load_addr_lo.
  - Half: lane mem_load_addr_lo[1]; bit 0 is ignored.
  - Word: addr_lo is ignored.
  - Sign-extend if mem_load_signed, else zero-extend.
  - Non-loads use mem_result.
- Mul/div handshake is valid/ready:
  - md_ready = buffer empty.
  - On md_valid & md_ready with md_rd!=0, the buffer captures {md_rd, md_result}.
  - md_rd=0 is accepted and discarded.
  - md_valid and its data are held stable until accepted.
  - Minimum md latency is 2 cycles: accept, buffer drain, rd_* output.
- Per-cycle source selection (one write at most):
  - force = buffer full & starve counter == STARVE_LIMIT.
  - force: write the buffer; mem_ready=0; the memory stage holds its inputs.
  - else mem_valid & mem_rd!=0: write the memory result; mem_ready=1.
  - else buffer full: write the buffer. A mem_valid with rd=0 is consumed the same cycle.
  - else: no write.
- Starve counter:
  - Increments each cycle the buffer is full and not drained.
  - Clears on drain or when the buffer is empty.
  - Saturates at STARVE_LIMIT.
- Scoreboard (pending_mask):
  - md_issue_valid with rd!=0 sets its bit.
  - A buffer drain clears the bit of the drained rd.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
  - pending_mask is registered and updates the cycle after the event.
- Reset mid-operation discards any buffered result and all pending bits.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined: adds output retire_count [63:0]. It increments by 1 in the cycle each rd_enable=1 write is presented, resets to 0, and wraps modulo 2^64.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Load lb, addr_lo=3, data 0x80AB_CDEF, signed, rd=5 -> next cycle rd_enable=1, rd_sel=5, rd_data=0xFFFF_FF80. Same with lhu, addr_lo=2 -> 0x0000_80AB.
- md_valid rd=7, result 0x1234 on an idle pipe -> md_ready=1; write appears 2 cycles later (rd_sel=7, rd_data=0x1234); md_ready low for exactly 1 cycle.
- Buffer full, continuous mem_valid rd=3, STARVE_LIMIT=4 -> 4 mem writes; then mem_ready=0 for 1 cycle while the buffer drains; then mem writes resume with held data.
- md_issue rd=9 -> pending_mask[9]=1 next cycle. Result for rd=9 drained in the same cycle as a new issue rd=9 -> bit stays 1.
- md_issue rd=0 and md_valid rd=0 -> pending_mask stays 0; no rd_enable; md_ready stays 1.
- rst_n pulsed low while buffer full and pending_mask=0x0000_0200 -> all outputs 0 immediately; md_ready=1 after release; with WB_RETIRE_COUNT_EN, retire_count=0.
